// File: rtl/fft8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft8_seq_ctrl
// Sequencer for an 8-point radix-2 DIT fixed-point FFT datapath.
// Carries no sample data: it produces RAM addresses, twiddle indices and
// strobes for a single shared butterfly unit.
//
// Frame flow: IDLE -> LOAD (8 samples, bit-reversed write addresses)
//   -> 3 x (CALC: 4 butterflies, one per cycle -> DRAIN: BFLY_LAT cycles)
//   -> UNLOAD (8 results, natural order) -> IDLE.
//
// Optional feature macro: FFT8_SEQ_SCALE_EN
//   Adds bf_scale (per-stage divide-by-2 strobe, asserted with bf_issue) and
//   scale_mask[2:0] (sampled on the first input handshake; bit s disables
//   scaling in stage s). Without the macro neither port exists and the
//   timing is identical.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input sample handshake
//   wr_en, wr_addr          RAM write strobe and bit-reversed load address
//   bf_issue                one butterfly starts this cycle
//   bf_addr_a / bf_addr_b   upper / lower butterfly RAM addresses
//   bf_tw, bf_stage         twiddle index k (W8^k), current stage 0..2
//   out_valid / out_ready   result handshake, rd_addr = natural-order index
//   out_last                asserted with the 8th result
//   busy                    high in every state except IDLE
// ---------------------------------------------------------------------------
module fft8_seq_ctrl #(
  parameter int BFLY_LAT = 3,
  parameter int N_PTS    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic       bf_issue,
  output logic [2:0] bf_addr_a,
  output logic [2:0] bf_addr_b,
  output logic [1:0] bf_tw,
  output logic [1:0] bf_stage,
`ifdef FFT8_SEQ_SCALE_EN
  output logic       bf_scale,
  input  logic [2:0] scale_mask,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] rd_addr,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_DRAIN  = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_INIT = 4'(BFLY_LAT);
  localparam logic [2:0] LAST_IDX   = 3'(N_PTS - 1);

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] k_q, k_d;
  logic [1:0] stage_q, stage_d;
  logic [3:0] drain_q, drain_d;
  logic [2:0] idx_q, idx_d;

  logic       in_ready_q, in_ready_d;
  logic       bf_issue_q, bf_issue_d;
  logic [2:0] bf_addr_a_q, bf_addr_a_d;
  logic [2:0] bf_addr_b_q, bf_addr_b_d;
  logic [1:0] bf_tw_q, bf_tw_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       busy_q, busy_d;
`ifdef FFT8_SEQ_SCALE_EN
  logic [2:0] mask_q, mask_d;
  logic       bf_scale_q, bf_scale_d;
`endif

  logic       hs_in_s, hs_out_s;
  logic [2:0] span_s, pos_s, grp_s, addr_a_s, addr_b_s;
  logic [1:0] tw_s;

  assign hs_in_s  = in_valid && in_ready_q;
  assign hs_out_s = out_valid_q && out_ready;

  // FSM next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    idx_d   = idx_q;
`ifdef FFT8_SEQ_SCALE_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (hs_in_s) begin
          state_d = S_LOAD;
          cnt_d   = 3'd1;
`ifdef FFT8_SEQ_SCALE_EN
          mask_d  = scale_mask;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (hs_in_s) begin
          if (cnt_q == 3'd7) begin
            state_d = S_CALC;
            cnt_d   = 3'd0;
            stage_d = 2'd0;
            k_d     = 2'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        if (k_q == 2'd3) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_INIT;
          k_d     = 2'd0;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DRAIN: begin
        // Wait for the last butterfly of this stage to be written back
        // before the next stage reads its operands.
        if (drain_q <= 4'd1) begin
          drain_d = 4'd0;
          if (stage_q == 2'd2) begin
            state_d = S_UNLOAD;
            idx_d   = 3'd0;
            stage_d = 2'd0;
          end else begin
            state_d = S_CALC;
            stage_d = stage_q + 2'd1;
            k_d     = 2'd0;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_UNLOAD: begin
        if (hs_out_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
        k_d     = 2'd0;
        stage_d = 2'd0;
        drain_d = 4'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Butterfly address/twiddle for the next (stage, k); the two terms of
  // addr_a occupy disjoint bits, so OR is the sum.
  always_comb begin
    span_s   = 3'd1 << stage_d;
    pos_s    = {1'b0, k_d} & (span_s - 3'd1);
    grp_s    = {1'b0, k_d} >> stage_d;
    addr_a_s = ((grp_s << 2'd1) << stage_d) | pos_s;
    addr_b_s = addr_a_s + span_s;
    tw_s     = pos_s[1:0] << (2'd2 - stage_d);
  end

  // Registered-output values derived from the next state
  always_comb begin
    in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
    bf_issue_d  = (state_d == S_CALC);
    out_valid_d = (state_d == S_UNLOAD);
    out_last_d  = (state_d == S_UNLOAD) && (idx_d == LAST_IDX);
    busy_d      = (state_d != S_IDLE);
    if (bf_issue_d) begin
      bf_addr_a_d = addr_a_s;
      bf_addr_b_d = addr_b_s;
      bf_tw_d     = tw_s;
    end else begin
      bf_addr_a_d = bf_addr_a_q;
      bf_addr_b_d = bf_addr_b_q;
      bf_tw_d     = bf_tw_q;
    end
`ifdef FFT8_SEQ_SCALE_EN
    bf_scale_d = bf_issue_d && !mask_d[stage_d];
`endif
  end

  // State, counters and outputs; rst_n aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      k_q         <= 2'd0;
      stage_q     <= 2'd0;
      drain_q     <= 4'd0;
      idx_q       <= 3'd0;
      in_ready_q  <= 1'b0;
      bf_issue_q  <= 1'b0;
      bf_addr_a_q <= 3'd0;
      bf_addr_b_q <= 3'd0;
      bf_tw_q     <= 2'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FFT8_SEQ_SCALE_EN
      mask_q      <= 3'd0;
      bf_scale_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      drain_q     <= drain_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      bf_issue_q  <= bf_issue_d;
      bf_addr_a_q <= bf_addr_a_d;
      bf_addr_b_q <= bf_addr_b_d;
      bf_tw_q     <= bf_tw_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
`ifdef FFT8_SEQ_SCALE_EN
      mask_q      <= mask_d;
      bf_scale_q  <= bf_scale_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = hs_in_s;
  assign wr_addr   = bitrev3(cnt_q);
  assign bf_issue  = bf_issue_q;
  assign bf_addr_a = bf_addr_a_q;
  assign bf_addr_b = bf_addr_b_q;
  assign bf_tw     = bf_tw_q;
  assign bf_stage  = stage_q;
  assign out_valid = out_valid_q;
  assign rd_addr   = idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
`ifdef FFT8_SEQ_SCALE_EN
  assign bf_scale  = bf_scale_q;
`endif

endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft8_seq_ctrl
// Scoreboard bench for fft8_seq_ctrl (BFLY_LAT = 3). The stimulus process
// pushes hand-computed expectations (write order, butterfly table, output
// order) before driving each frame; a negedge monitor pops and compares
// whenever the DUT strobes wr_en, bf_issue or an output handshake.
// ---------------------------------------------------------------------------
module tb_fft8_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic       bf_issue;
  logic [2:0] bf_addr_a;
  logic [2:0] bf_addr_b;
  logic [1:0] bf_tw;
  logic [1:0] bf_stage;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] rd_addr;
  logic       out_last;
  logic       busy;
`ifdef FFT8_SEQ_SCALE_EN
  logic       bf_scale;
  logic [2:0] scale_mask;
`endif

  fft8_seq_ctrl #(.BFLY_LAT(3), .N_PTS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .bf_issue  (bf_issue),
    .bf_addr_a (bf_addr_a),
    .bf_addr_b (bf_addr_b),
    .bf_tw     (bf_tw),
    .bf_stage  (bf_stage),
`ifdef FFT8_SEQ_SCALE_EN
    .bf_scale  (bf_scale),
    .scale_mask(scale_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd_addr   (rd_addr),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed reference tables
  localparam logic [2:0] WR_ORDER [8]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  localparam logic [2:0] EXP_A    [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  localparam logic [2:0] EXP_B    [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [1:0] EXP_TW   [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [1:0] EXP_ST   [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
  localparam logic [3:0] EXP_GAP  [12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0};
  localparam logic       OR_PAT   [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
  localparam int         EXP_LATENCY   = 21;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] st;
    logic       sc;
    logic [3:0] gap;
  } bf_exp_t;

  logic [2:0] wr_q  [$];
  bf_exp_t    bf_q  [$];
  logic [2:0] out_q [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total = total + 1;
    if (act != exp_v) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         ref_cyc = 0;
  int         hs_cyc = 0;
  int         wr_cnt = 0;
  bit         ready_chk = 1'b0;
  bit         valid_chk = 1'b0;
  bit         busy_chk = 1'b0;
  bit         stall_prev = 1'b0;
  bit         have_last = 1'b0;
  logic [2:0] prev_rd;
  logic [2:0] m_e;
  bf_exp_t    m_b;
  bf_exp_t    last_b;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      wr_cnt     = 0;
      ready_chk  = 1'b0;
      valid_chk  = 1'b0;
      busy_chk   = 1'b0;
      stall_prev = 1'b0;
      have_last  = 1'b0;
    end else begin
      if (ready_chk) begin
        chk("in_ready_drop", int'(in_ready), 0);
        ready_chk = 1'b0;
      end
      if (busy_chk) begin
        chk("busy_drop", int'(busy), 0);
        busy_chk = 1'b0;
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          m_e = wr_q.pop_front();
          chk("wr_addr", int'(wr_addr), int'(m_e));
        end
        wr_cnt = wr_cnt + 1;
        if (wr_cnt == 8) begin
          wr_cnt    = 0;
          hs_cyc    = cyc;
          ref_cyc   = cyc;
          ready_chk = 1'b1;
          valid_chk = 1'b1;
        end
      end
      if (bf_issue) begin
        if (bf_q.size() == 0) begin
          chk("bf_unexpected", 1, 0);
        end else begin
          m_b = bf_q.pop_front();
          chk("bf_addr_a", int'(bf_addr_a), int'(m_b.a));
          chk("bf_addr_b", int'(bf_addr_b), int'(m_b.b));
          chk("bf_tw", int'(bf_tw), int'(m_b.tw));
          chk("bf_stage", int'(bf_stage), int'(m_b.st));
          chk("bf_gap", cyc - ref_cyc - 1, int'(m_b.gap));
`ifdef FFT8_SEQ_SCALE_EN
          chk("bf_scale", int'(bf_scale), int'(m_b.sc));
`endif
          last_b    = m_b;
          have_last = 1'b1;
        end
        ref_cyc = cyc;
      end else if (have_last) begin
        chk("bf_hold_a", int'(bf_addr_a), int'(last_b.a));
        chk("bf_hold_b", int'(bf_addr_b), int'(last_b.b));
        chk("bf_hold_tw", int'(bf_tw), int'(last_b.tw));
      end
      if (out_valid) begin
        // out_valid rises on the 21st clock edge after the edge that
        // accepted the 8th sample.
        if (valid_chk) begin
          chk("latency", cyc - hs_cyc - 1, EXP_LATENCY);
          valid_chk = 1'b0;
        end
        if (stall_prev) begin
          chk("rd_hold", int'(rd_addr), int'(prev_rd));
        end
        if (out_ready) begin
          if (out_q.size() == 0) begin
            chk("out_unexpected", 1, 0);
          end else begin
            m_e = out_q.pop_front();
            chk("rd_addr", int'(rd_addr), int'(m_e));
            chk("out_last", int'(out_last), (m_e == 3'd7) ? 1 : 0);
            if (m_e == 3'd7) busy_chk = 1'b1;
          end
        end
        stall_prev = !out_ready;
        prev_rd    = rd_addr;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_frame(input logic [2:0] mask);
    bf_exp_t e;
    for (int i = 0; i < 8; i++) wr_q.push_back(WR_ORDER[i]);
    for (int i = 0; i < 12; i++) begin
      e.a   = EXP_A[i];
      e.b   = EXP_B[i];
      e.tw  = EXP_TW[i];
      e.st  = EXP_ST[i];
      e.sc  = !mask[EXP_ST[i]];
      e.gap = EXP_GAP[i];
      bf_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) out_q.push_back(3'(i));
  endtask

  task automatic load_frame(input bit gapped, input logic [2:0] mask);
    int n = 0;
    int g = 0;
    bit hs;
`ifdef FFT8_SEQ_SCALE_EN
    scale_mask = mask;
`else
    if (mask != 3'd0) n = 0;
`endif
    while (n < 8 && g < 100) begin
      in_valid = gapped ? ((g % 3) != 2) : 1'b1;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) n = n + 1;
      g = g + 1;
    end
    in_valid = 1'b0;
    if (n < 8) chk("load_timeout", n, 8);
  endtask

  task automatic unload_frame(input bit bp);
    int n = 0;
    int g = 0;
    bit hs;
    while (n < 8 && g < 200) begin
      out_ready = bp ? OR_PAT[g % 4] : 1'b1;
      @(negedge clk);
      hs = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (hs) n = n + 1;
      g = g + 1;
    end
    out_ready = 1'b1;
    if (n < 8) chk("unload_timeout", n, 8);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"},  int'(in_ready),  0);
    chk({tag, "_wr_en"},     int'(wr_en),     0);
    chk({tag, "_wr_addr"},   int'(wr_addr),   0);
    chk({tag, "_bf_issue"},  int'(bf_issue),  0);
    chk({tag, "_bf_addr_a"}, int'(bf_addr_a), 0);
    chk({tag, "_bf_addr_b"}, int'(bf_addr_b), 0);
    chk({tag, "_bf_tw"},     int'(bf_tw),     0);
    chk({tag, "_bf_stage"},  int'(bf_stage),  0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_rd_addr"},   int'(rd_addr),   0);
    chk({tag, "_out_last"},  int'(out_last),  0);
    chk({tag, "_busy"},      int'(busy),      0);
`ifdef FFT8_SEQ_SCALE_EN
    chk({tag, "_bf_scale"},  int'(bf_scale),  0);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  g;
    bit  found;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef FFT8_SEQ_SCALE_EN
    scale_mask = 3'd0;
`endif
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_busy", int'(busy), 0);

    // Frame 1: back-to-back load, out_ready held high
    expect_frame(3'b010);
    load_frame(1'b0, 3'b010);
    unload_frame(1'b0);

    // Frame 2: gapped in_valid, out_ready toggling 1,0,0,1
    expect_frame(3'b101);
    load_frame(1'b1, 3'b101);
    unload_frame(1'b1);

    // Frame 3: aborted by reset at stage 1, k=2
    expect_frame(3'b000);
    load_frame(1'b0, 3'b000);
    g = 0;
    found = 1'b0;
    while (!found && g < 100) begin
      @(negedge clk);
      found = bf_issue && (bf_stage == 2'd1) && (bf_addr_a == 3'd4);
      g = g + 1;
    end
    chk("rst_point_found", int'(found), 1);
    #1;
    rst_n = 1'b0;
    #1;
    wr_q.delete();
    bf_q.delete();
    out_q.delete();
    check_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Any output strobe in this window finds an empty queue and is flagged.
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_busy", int'(busy), 0);

    // Frame 4: full frame after the abort
    expect_frame(3'b000);
    load_frame(1'b0, 3'b000);
    unload_frame(1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("wr_q_left", wr_q.size(), 0);
    chk("bf_q_left", bf_q.size(), 0);
    chk("out_q_left", out_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if the sequence above never completes
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft8_seq_ctrl.md
Name: fft8_seq_ctrl

Overview:
- Sequencer for the 8-point radix-2 DIT fixed-point FFT datapath.
- Accepts 8 input samples over a valid/ready handshake and generates bit-reversed write addresses into the datapath sample RAM.
- Issues 12 butterfly operations (3 stages x 4), one per cycle, using a single shared butterfly unit, with a drain gap between stages.
- Streams the 8 results out in natural order. Carries no sample data; it produces addresses, twiddle indices and strobes only.

Parameters:
- BFLY_LAT, 3, cycles from bf_issue until that butterfly's result is written back to RAM (valid range 1..15).
- N_PTS, 8, transform size; fixed at 8, present for interface documentation only.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller can accept a sample.
- wr_en  out  1  write input sample to RAM; equals in_valid && in_ready.
- wr_addr  out  3  bit-reversed load index.
- bf_issue  out  1  start one butterfly this cycle.
- bf_addr_a  out  3  upper butterfly RAM address.
- bf_addr_b  out  3  lower butterfly RAM address.
- bf_tw  out  2  twiddle index k, for W8^k.
- bf_stage  out  2  current stage, 0..2.
- out_valid  out  1  result at rd_addr is valid.
- out_ready  in  1  consumer accepts result.
- rd_addr  out  3  natural-order output read address.
- out_last  out  1  asserted with the 8th result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- An rst_n assertion in any state aborts the frame immediately. No partial output is emitted afterwards.
- FSM states: IDLE, LOAD, CALC, DRAIN, UNLOAD.
- IDLE:
  - in_ready=1.
  - A handshake moves the FSM to LOAD with load count 1; that sample is written at wr_addr=0.
- LOAD:
  - in_ready=1.
  - Each handshake writes at wr_addr=bitrev3(cnt), then increments cnt.
  - The 8th handshake (cnt=7) moves the FSM to CALC with stage=0, k=0.
  - in_valid low simply stalls; there is no timeout.
- CALC:
  - bf_issue=1 every cycle.
  - span=1<<stage, pos=k&(span-1), grp=k>>stage.
  - bf_addr_a=grp*2*span+pos; bf_addr_b=bf_addr_a+span; bf_tw=pos<<(2-stage).
  - k increments each cycle. After k=3 the FSM moves to DRAIN with drain counter=BFLY_LAT.
- DRAIN:
  - bf_issue=0.
  - The drain counter decrements each cycle. At 1:
    - stage<2: stage++, k=0, back to CALC.
    - stage=2: go to UNLOAD with idx=0.
  - DRAIN guarantees no read-after-write hazard across stages.
- UNLOAD:
  - out_valid=1, rd_addr=idx.
  - On out_valid && out_ready, idx increments.
  - out_last=1 when idx=7. The handshake at idx=7 returns the FSM to IDLE.
  - out_ready low holds rd_addr and out_valid stable.
- in_ready=0 in CALC, DRAIN and UNLOAD. Input is not overlapped with output; a new frame starts only from IDLE.
- Frame latency from 8th input handshake to first out_valid: 3*(4+BFLY_LAT) cycles. Default: 21.
- bf_addr_a, bf_addr_b and bf_tw are registered and change only on cycles where bf_issue is asserted. They hold their last value otherwise.

Optional Feature:
- Macro: FFT8_SEQ_SCALE_EN.
- When defined:
  - Adds output bf_scale (1 bit), asserted together with bf_issue.
  - The datapath divides butterfly outputs by 2 each stage (overall 1/8), preventing fixed-point growth.
  - Adds input scale_mask[2:0], sampled in IDLE on the first handshake; bit s disables scaling in stage s.
- When undefined:
  - Neither port exists.
  - The datapath applies no scaling and the timing is identical.

Test Plan:
- Reset then load: drive 8 back-to-back samples -> wr_addr sequence 0,4,2,6,1,5,3,7; in_ready drops the cycle after the 8th handshake.
- Butterfly sequence, BFLY_LAT=3 -> 12 issues:
  - stage 0 (a,b,tw): (0,1,0),(2,3,0),(4,5,0),(6,7,0);
  - stage 1: (0,2,0),(1,3,2),(4,6,0),(5,7,2);
  - stage 2: (0,4,0),(1,5,1),(2,6,2),(3,7,3);
  - exactly 3 idle cycles between stages.
- Latency: out_ready held high -> first out_valid 21 cycles after 8th input handshake; rd_addr 0..7 on consecutive cycles; out_last only at rd_addr=7; busy drops the next cycle.
- Backpressure: toggle out_ready 1,0,0,1,... in UNLOAD -> rd_addr holds while low, no skipped or repeated index; gapped in_valid in LOAD -> wr_addr order unchanged.
- Mid-frame reset: assert rst_n low during CALC stage 1, k=2 -> all outputs 0 asynchronously; after release a full new frame completes normally.
- FFT8_SEQ_SCALE_EN with scale_mask=3'b010 -> bf_scale=1 for stage 0 and 2 issues, 0 for stage 1 issues.
